// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller sitting directly downstream of baudrate_gen.
// It synchronises the RX line and detects the start-bit falling edge.
// It gates the generator's RX counter and samples one bit on each mid-bit tick.
// It deserialises an 8N1 frame, LSB first, and reports each frame with a
// one-cycle valid or frame-error pulse.
// Optional feature macro: UART_RX_PARITY_EN. When it is defined, the module
// expects one parity bit between the data bits and the stop bit, and adds the
// P_PARITY_ODD parameter and the O_rx_parity_err output.
module uart_rx_ctrl #(
  parameter int unsigned P_SYNC_STAGES = 2,
  parameter int unsigned P_DATA_BITS   = 8
`ifdef UART_RX_PARITY_EN
  ,
  parameter int unsigned P_PARITY_ODD  = 0
`endif
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   I_rx,
  input  logic                   I_baudrate_rx_clk,
  output logic                   O_baudrate_rx_clk_en,
  output logic [P_DATA_BITS-1:0] O_rx_data,
  output logic                   O_rx_valid,
  output logic                   O_rx_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                   O_rx_parity_err,
`endif
  output logic                   O_rx_busy
);

  localparam int unsigned          IDX_W    = $clog2(P_DATA_BITS);
  localparam logic [IDX_W-1:0]     LAST_IDX = IDX_W'(P_DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam logic                 ODD      = (P_PARITY_ODD != 0);
`endif

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;
`endif

  state_t                 state;
  logic [P_SYNC_STAGES-1:0] sync;
  logic                   rx_sync;
  logic                   rx_prev;
  logic                   rx_fall;
  logic [P_DATA_BITS-1:0] shift;
  logic [IDX_W-1:0]       idx;
`ifdef UART_RX_PARITY_EN
  logic                   par_bad;
`endif

  // RX line synchroniser; resets to the idle level so reset release never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '1;
    end else begin
      sync <= {sync[P_SYNC_STAGES-2:0], I_rx};
    end
  end

  assign rx_sync = sync[P_SYNC_STAGES-1];

  // One extra flop behind the synchroniser for falling-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_prev <= 1'b1;
    end else begin
      rx_prev <= rx_sync;
    end
  end

  assign rx_fall = rx_prev & ~rx_sync;

  // Frame state machine with registered enable, data and status pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                <= S_IDLE;
      O_baudrate_rx_clk_en <= 1'b0;
      O_rx_data            <= '0;
      O_rx_valid           <= 1'b0;
      O_rx_frame_err       <= 1'b0;
      shift                <= '0;
      idx                  <= '0;
`ifdef UART_RX_PARITY_EN
      O_rx_parity_err      <= 1'b0;
      par_bad              <= 1'b0;
`endif
    end else begin
      O_rx_valid     <= 1'b0;
      O_rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      O_rx_parity_err <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          // Ticks are ignored here; only a real 1->0 transition starts a frame
          if (rx_fall) begin
            state                <= S_START;
            O_baudrate_rx_clk_en <= 1'b1;
          end
        end
        S_START: begin
          if (I_baudrate_rx_clk) begin
            if (!rx_sync) begin
              state <= S_DATA;
              idx   <= '0;
            end else begin
              // Line back high at mid start bit: treat it as a glitch
              state                <= S_IDLE;
              O_baudrate_rx_clk_en <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (I_baudrate_rx_clk) begin
            shift <= {rx_sync, shift[P_DATA_BITS-1:1]};
            idx   <= idx + 1'b1;
            if (idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (I_baudrate_rx_clk) begin
            par_bad <= rx_sync ^ (^shift) ^ ODD;
            state   <= S_STOP;
          end
        end
`endif
        S_STOP: begin
          if (I_baudrate_rx_clk) begin
            state                <= S_IDLE;
            O_baudrate_rx_clk_en <= 1'b0;
            if (!rx_sync) begin
              O_rx_frame_err <= 1'b1;
`ifdef UART_RX_PARITY_EN
            end else if (par_bad) begin
              O_rx_parity_err <= 1'b1;
`endif
            end else begin
              O_rx_data  <= shift;
              O_rx_valid <= 1'b1;
            end
          end
        end
        default: begin
          state                <= S_IDLE;
          O_baudrate_rx_clk_en <= 1'b0;
        end
      endcase
    end
  end

  assign O_rx_busy = (state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl. It includes a simple baudrate_gen model
// at 434 clk per bit, whose first tick falls half a bit after the enable rises.
module tb_uart_rx_ctrl;

  localparam int BIT_CLKS = 434;
  localparam int HALF     = BIT_CLKS >> 1;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       tick;
  logic       en;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       perr;
`endif

  int total  = 0;
  int passed = 0;
  int cyc    = 0;

  int valid_cycles;
  int ferr_cycles;
  int perr_cycles;
  int both_seen;
  int en_seen;
  int last_valid_cyc;
  int start_cyc;
  logic [7:0] rx_log[$];

  int gen_cnt;

  uart_rx_ctrl #(.P_SYNC_STAGES(2), .P_DATA_BITS(8)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .I_rx                 (rx),
    .I_baudrate_rx_clk    (tick),
    .O_baudrate_rx_clk_en (en),
    .O_rx_data            (data),
    .O_rx_valid           (valid),
    .O_rx_frame_err       (ferr),
`ifdef UART_RX_PARITY_EN
    .O_rx_parity_err      (perr),
`endif
    .O_rx_busy            (busy)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Generator model: counter held at 0 while disabled, tick at mid-bit
  always @(posedge clk) begin
    if (!en) gen_cnt <= 0;
    else     gen_cnt <= (gen_cnt == BIT_CLKS - 1) ? 0 : gen_cnt + 1;
  end
  assign tick = en && (gen_cnt == HALF - 1);

  // Output monitor sampled away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid) begin
        valid_cycles++;
        last_valid_cyc = cyc;
        rx_log.push_back(data);
      end
      if (ferr) ferr_cycles++;
`ifdef UART_RX_PARITY_EN
      if (perr) perr_cycles++;
`endif
      if (valid && ferr) both_seen++;
      if (en) en_seen = 1;
    end
  end

  task automatic clear_mon();
    valid_cycles = 0;
    ferr_cycles  = 0;
    perr_cycles  = 0;
    both_seen    = 0;
    en_seen      = 0;
    last_valid_cyc = 0;
    rx_log.delete();
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic par_flip);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit((^d) ^ par_flip);
`else
    if (par_flip) drive_bit(1'b1);
`endif
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    rx    = 1'b1;
    clear_mon();
    repeat (3) @(negedge clk);
    total++; if (en !== 1'b0)      $display("FAIL rst_en: got %0h want 0", en);       else passed++;
    total++; if (valid !== 1'b0)   $display("FAIL rst_valid: got %0h want 0", valid); else passed++;
    total++; if (ferr !== 1'b0)    $display("FAIL rst_ferr: got %0h want 0", ferr);   else passed++;
    total++; if (busy !== 1'b0)    $display("FAIL rst_busy: got %0h want 0", busy);   else passed++;
    total++; if (data !== 8'h00)   $display("FAIL rst_data: got %0h want 00", data);  else passed++;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    total++; if (busy !== 1'b0 || en !== 1'b0)
      $display("FAIL rst_release_idle: got busy=%0h en=%0h want 0/0", busy, en); else passed++;
  endtask

  task automatic test_basic_frame();
    int lat;
    clear_mon();
    send_frame(8'h55, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    lat = last_valid_cyc - start_cyc;
    total++; if (valid_cycles !== 1) $display("FAIL basic_valid_cycles: got %0d want 1", valid_cycles); else passed++;
    total++; if (data !== 8'h55)     $display("FAIL basic_data: got %0h want 55", data); else passed++;
    total++; if (ferr_cycles !== 0)  $display("FAIL basic_ferr: got %0d want 0", ferr_cycles); else passed++;
    total++; if (lat < (FRAME_BITS - 1) * BIT_CLKS + 150 || lat > (FRAME_BITS - 1) * BIT_CLKS + 300)
      $display("FAIL basic_latency: got %0d want about %0d", lat, (FRAME_BITS - 1) * BIT_CLKS + HALF); else passed++;
    total++; if (en !== 1'b0 || busy !== 1'b0)
      $display("FAIL basic_idle_after: got en=%0h busy=%0h want 0/0", en, busy); else passed++;
  endtask

  task automatic test_frame_err();
    clear_mon();
    send_frame(8'hF0, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (ferr_cycles !== 1)  $display("FAIL ferr_cycles: got %0d want 1", ferr_cycles); else passed++;
    total++; if (valid_cycles !== 0) $display("FAIL ferr_no_valid: got %0d want 0", valid_cycles); else passed++;
    total++; if (data !== 8'h55)     $display("FAIL ferr_data_held: got %0h want 55", data); else passed++;
    total++; if (busy !== 1'b0)      $display("FAIL ferr_idle: got %0h want 0", busy); else passed++;
  endtask

  task automatic test_back_to_back();
    clear_mon();
    send_frame(8'hA3, 1'b1, 1'b0);
    send_frame(8'h00, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (valid_cycles !== 2) $display("FAIL b2b_valid_cycles: got %0d want 2", valid_cycles); else passed++;
    total++; if (rx_log.size() !== 2) $display("FAIL b2b_log_size: got %0d want 2", rx_log.size()); else passed++;
    if (rx_log.size() == 2) begin
      total++; if (rx_log[0] !== 8'hA3) $display("FAIL b2b_first: got %0h want a3", rx_log[0]); else passed++;
      total++; if (rx_log[1] !== 8'h00) $display("FAIL b2b_second: got %0h want 00", rx_log[1]); else passed++;
    end
    total++; if (ferr_cycles !== 0 || both_seen !== 0)
      $display("FAIL b2b_errors: got ferr=%0d both=%0d want 0/0", ferr_cycles, both_seen); else passed++;
  endtask

  task automatic test_glitch();
    clear_mon();
    rx = 1'b0;
    repeat (100) @(negedge clk);
    rx = 1'b1;
    repeat (400) @(negedge clk);
    total++; if (en_seen !== 1)  $display("FAIL glitch_en_rose: got %0d want 1", en_seen); else passed++;
    total++; if (en !== 1'b0)    $display("FAIL glitch_en_fell: got %0h want 0", en); else passed++;
    total++; if (busy !== 1'b0)  $display("FAIL glitch_idle: got %0h want 0", busy); else passed++;
    total++; if (valid_cycles !== 0 || ferr_cycles !== 0)
      $display("FAIL glitch_no_pulse: got valid=%0d ferr=%0d want 0/0", valid_cycles, ferr_cycles); else passed++;
  endtask

  task automatic test_break();
    clear_mon();
    rx = 1'b0;
    repeat (FRAME_BITS * BIT_CLKS + 3 * BIT_CLKS) @(negedge clk);
    total++; if (ferr_cycles !== 1)  $display("FAIL break_ferr: got %0d want 1", ferr_cycles); else passed++;
    total++; if (valid_cycles !== 0) $display("FAIL break_no_valid: got %0d want 0", valid_cycles); else passed++;
    total++; if (busy !== 1'b0 || en !== 1'b0)
      $display("FAIL break_stays_idle: got busy=%0h en=%0h want 0/0", busy, en); else passed++;
    rx = 1'b1;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d;
    d = 8'h3C;
    clear_mon();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    rx = d[4];
    repeat (200) @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL rstmid_busy_before: got %0h want 1", busy); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (en !== 1'b0)    $display("FAIL rstmid_en: got %0h want 0", en); else passed++;
    total++; if (busy !== 1'b0)  $display("FAIL rstmid_busy: got %0h want 0", busy); else passed++;
    total++; if (valid !== 1'b0) $display("FAIL rstmid_valid: got %0h want 0", valid); else passed++;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    total++; if (valid_cycles !== 0 || ferr_cycles !== 0)
      $display("FAIL rstmid_no_pulse: got valid=%0d ferr=%0d want 0/0", valid_cycles, ferr_cycles); else passed++;
    clear_mon();
    send_frame(8'h81, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (valid_cycles !== 1) $display("FAIL rstmid_next_valid: got %0d want 1", valid_cycles); else passed++;
    total++; if (data !== 8'h81)     $display("FAIL rstmid_next_data: got %0h want 81", data); else passed++;
    total++; if (ferr_cycles !== 0)  $display("FAIL rstmid_next_ferr: got %0d want 0", ferr_cycles); else passed++;
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (20) @(negedge clk);
    total++; if (perr_cycles !== 1)  $display("FAIL par_bad_perr: got %0d want 1", perr_cycles); else passed++;
    total++; if (valid_cycles !== 0) $display("FAIL par_bad_no_valid: got %0d want 0", valid_cycles); else passed++;
    total++; if (data !== 8'h81)     $display("FAIL par_bad_data_held: got %0h want 81", data); else passed++;
    clear_mon();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (20) @(negedge clk);
    total++; if (valid_cycles !== 1) $display("FAIL par_ok_valid: got %0d want 1", valid_cycles); else passed++;
    total++; if (data !== 8'h07)     $display("FAIL par_ok_data: got %0h want 07", data); else passed++;
    total++; if (perr_cycles !== 0)  $display("FAIL par_ok_perr: got %0d want 0", perr_cycles); else passed++;
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic_frame();
    test_frame_err();
    test_back_to_back();
    test_glitch();
    test_break();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
